// File: rtl/blit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blit_pkg
//  Description : Shared types and sizing constants for the sprite blitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package blit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } blit_state_t;

    localparam int unsigned SCREEN_W_DEFAULT    = 640;
    localparam int unsigned SCREEN_H_DEFAULT    = 480;
    localparam logic [4:0]  TRANSPARENT_DEFAULT = 5'h1F;

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned SUM_W   = 12;
    localparam int unsigned DIM_W   = 6;
    localparam int unsigned ROM_AW  = 11;
    localparam int unsigned COLOR_W = 5;

endpackage
`default_nettype wire

// File: rtl/sprite_blitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter_if
//  Description : Command, sprite-ROM and frame-buffer bundle of the blitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_blitter_if;

    logic                               cmd_valid;
    logic                               cmd_ready;
    logic [blit_pkg::COORD_W-1:0]       cmd_x;
    logic [blit_pkg::COORD_W-1:0]       cmd_y;
    logic [blit_pkg::DIM_W-1:0]         cmd_w;
    logic [blit_pkg::DIM_W-1:0]         cmd_h;
    logic [blit_pkg::ROM_AW-1:0]        cmd_base;
    logic [blit_pkg::ROM_AW-1:0]        rom_addr;
    logic [blit_pkg::COLOR_W-1:0]       rom_data;
    logic                               fb_we;
    logic [blit_pkg::ADDR_W-1:0]        fb_addr;
    logic [blit_pkg::COLOR_W-1:0]       fb_data;
    logic                               fb_ready;
    logic                               done;

    // master = the blitter, slave = the command source / ROM / frame buffer
    modport master (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base, rom_data, fb_ready,
        output cmd_ready, rom_addr, fb_we, fb_addr, fb_data, done
    );

    modport slave (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base, rom_data, fb_ready,
        input  cmd_ready, rom_addr, fb_we, fb_addr, fb_data, done
    );

endinterface
`default_nettype wire

// File: rtl/fb_addr_calc.sv
`default_nettype none
// ============================================================================
//  Module      : fb_addr_calc
//  Description : Screen X,Y to linear frame-buffer address plus bounds flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_addr_calc
    import blit_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic [SUM_W-1:0]  i_x,
    input  logic [SUM_W-1:0]  i_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_bounds
);

    localparam logic [ADDR_W-1:0] c_W_ADDR = ADDR_W'(SCREEN_W);
    localparam logic [SUM_W-1:0]  c_W_SUM  = SUM_W'(SCREEN_W);
    localparam logic [SUM_W-1:0]  c_H_SUM  = SUM_W'(SCREEN_H);

    logic [ADDR_W-1:0] w_row_base;

    // Out-of-range coordinates may overflow here; they are never written.
    assign w_row_base  = ADDR_W'(i_y) * c_W_ADDR;
    assign o_addr      = w_row_base + ADDR_W'(i_x);
    assign o_in_bounds = (i_x < c_W_SUM) && (i_y < c_H_SUM);

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter
//  Description : Copies a row-major sprite from ROM into the frame buffer,
//                skipping transparent and off-screen pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int unsigned         SCREEN_W    = SCREEN_W_DEFAULT,
    parameter int unsigned         SCREEN_H    = SCREEN_H_DEFAULT,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    sprite_blitter_if.master bus
);

    blit_state_t r_state, w_state_next;

    logic [COORD_W-1:0] r_x, r_y;
    logic [DIM_W-1:0]   r_w, r_h, r_col, r_row;
    logic [ROM_AW-1:0]  r_ptr;
    logic               r_fb_we, r_done;
    logic [ADDR_W-1:0]  r_fb_addr;
    logic [COLOR_W-1:0] r_fb_data;

    logic               w_accept, w_retire, w_zero, w_col_last, w_last;
    logic               w_in_bounds, w_pix_we;
    logic [SUM_W-1:0]   w_x_sum, w_y_sum;
    logic [ADDR_W-1:0]  w_addr;

    assign w_x_sum    = SUM_W'(r_x) + SUM_W'(r_col);
    assign w_y_sum    = SUM_W'(r_y) + SUM_W'(r_row);
    assign w_zero     = (bus.cmd_w == '0) || (bus.cmd_h == '0);
    assign w_col_last = (r_col == r_w - DIM_W'(1));
    assign w_last     = w_col_last && (r_row == r_h - DIM_W'(1));
    assign w_pix_we   = w_in_bounds && (bus.rom_data != TRANSPARENT);

    fb_addr_calc #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_addr_calc (
        .i_x         (w_x_sum),
        .i_y         (w_y_sum),
        .o_addr      (w_addr),
        .o_in_bounds (w_in_bounds)
    );

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    if (!w_zero) w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: w_state_next = ST_WRITE;
            ST_WRITE: begin
                // Skipped pixels never wait for the frame buffer.
                if (!r_fb_we || bus.fb_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = w_last ? ST_IDLE : ST_FETCH;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_ptr     <= '0;
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_x    <= bus.cmd_x;
                r_y    <= bus.cmd_y;
                r_w    <= bus.cmd_w;
                r_h    <= bus.cmd_h;
                r_col  <= '0;
                r_row  <= '0;
                r_ptr  <= bus.cmd_base;
                r_done <= w_zero;
            end
            // ROM data for r_ptr is valid at the end of FETCH.
            if (r_state == ST_FETCH) begin
                r_fb_data <= bus.rom_data;
                r_fb_addr <= w_addr;
                r_fb_we   <= w_pix_we;
            end
            if (w_retire) begin
                r_fb_we <= 1'b0;
                r_ptr   <= r_ptr + ROM_AW'(1);
                r_done  <= w_last;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_W'(1);
                end else begin
                    r_col <= r_col + DIM_W'(1);
                end
            end
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.rom_addr  = r_ptr;
    assign bus.fb_we     = r_fb_we;
    assign bus.fb_addr   = r_fb_addr;
    assign bus.fb_data   = r_fb_data;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_blitter
//  Description : Directed vector bench for sprite_blitter with ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #10 Clk = ~Clk;

    sprite_blitter_if bus();

    sprite_blitter #(
        .SCREEN_W    (640),
        .SCREEN_H    (480),
        .TRANSPARENT (5'h1F)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [4:0] rom [0:2047];
    assign bus.rom_data = rom[bus.rom_addr];

    typedef struct packed {
        int                x, y, w, h, base;
        logic [3:0][4:0]   pat;
        int                n_exp;
        logic [3:0][18:0]  exp_addr;
        logic [3:0][4:0]   exp_data;
        int                exp_lat;
    } vec_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [4:0]  data;
    } wr_t;

    wr_t  wq[$];
    int   cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0;
    int   n_cmp = 0, n_fail = 0;
    vec_t vecs[9];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (bus.fb_we && bus.fb_ready) wq.push_back({bus.fb_addr, bus.fb_data});
        if (!Reset && bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
        if (bus.done) begin
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    function automatic vec_t mk(input int x, y, w, h, base, input logic [3:0][4:0] pat,
                                input int n, input logic [3:0][18:0] a,
                                input logic [3:0][4:0] d, input int lat);
        vec_t v;
        v.x = x; v.y = y; v.w = w; v.h = h; v.base = base; v.pat = pat;
        v.n_exp = n; v.exp_addr = a; v.exp_data = d; v.exp_lat = lat;
        return v;
    endfunction

    task automatic load_rom(input vec_t v);
        for (int i = 0; i < 4; i++) rom[(v.base + i) & 2047] = v.pat[i];
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_x    = 10'(v.x);
        bus.cmd_y    = 10'(v.y);
        bus.cmd_w    = 6'(v.w);
        bus.cmd_h    = 6'(v.h);
        bus.cmd_base = 11'(v.base);
    endtask

    // Latency = clock edges from the accepting edge to the edge that raises done.
    task automatic wait_and_check(input vec_t v, input int exp_lat, input string tag, input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) step();
        repeat (4) step();
        chk({tag, " done pulses"}, done_cnt - d0, 1);
        chk({tag, " latency"}, done_cyc - acc_cyc - 1, exp_lat);
        chk({tag, " write count"}, wq.size(), v.n_exp);
        for (int i = 0; i < v.n_exp; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("%s wr%0d addr", tag, i), int'(wq[i].addr), int'(v.exp_addr[i]));
                chk($sformatf("%s wr%0d data", tag, i), int'(wq[i].data), int'(v.exp_data[i]));
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int d0;
        load_rom(v);
        wq.delete();
        d0 = done_cnt;
        @(posedge Clk); #1;
        drive_cmd(v);
        bus.cmd_valid = 1'b1;
        @(posedge Clk); #1;
        // A different command offered while busy must be ignored.
        if (v.w * v.h >= 2) begin
            bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = 6'd1; bus.cmd_h = 6'd1; bus.cmd_base = '0;
            repeat (2) begin @(posedge Clk); #1; end
        end
        bus.cmd_valid = 1'b0;
        wait_and_check(v, v.exp_lat, tag, d0);
    endtask

    initial begin
        int   d0, n_w, found;
        vec_t blk;

        for (int i = 0; i < 2048; i++) rom[i] = 5'd0;
        bus.cmd_valid = 1'b0; bus.fb_ready = 1'b1;
        bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_base = '0;

        vecs[0] = mk(10, 20, 2, 2, 0, {5'd6, 5'd5, 5'd4, 5'd3}, 4,
                     {19'd13451, 19'd13450, 19'd12811, 19'd12810}, {5'd6, 5'd5, 5'd4, 5'd3}, 8);
        vecs[1] = mk(10, 20, 2, 2, 0, {5'd6, 5'd5, 5'd31, 5'd3}, 3,
                     {19'd0, 19'd13451, 19'd13450, 19'd12810}, {5'd0, 5'd6, 5'd5, 5'd3}, 8);
        vecs[2] = mk(639, 479, 2, 2, 100, {5'd10, 5'd9, 5'd8, 5'd7}, 1,
                     {19'd0, 19'd0, 19'd0, 19'd307199}, {5'd0, 5'd0, 5'd0, 5'd7}, 8);
        vecs[3] = mk(0, 0, 1, 1, 2047, {5'd0, 5'd0, 5'd0, 5'd1}, 1,
                     {19'd0, 19'd0, 19'd0, 19'd0}, {5'd0, 5'd0, 5'd0, 5'd1}, 2);
        vecs[4] = mk(5, 0, 3, 1, 2046, {5'd0, 5'd9, 5'd31, 5'd2}, 2,
                     {19'd0, 19'd0, 19'd7, 19'd5}, {5'd0, 5'd0, 5'd9, 5'd2}, 6);
        vecs[5] = mk(638, 0, 4, 1, 10, {5'd4, 5'd3, 5'd2, 5'd1}, 2,
                     {19'd0, 19'd0, 19'd639, 19'd638}, {5'd0, 5'd0, 5'd2, 5'd1}, 8);
        vecs[6] = mk(0, 478, 1, 4, 20, {5'd4, 5'd3, 5'd2, 5'd1}, 2,
                     {19'd0, 19'd0, 19'd306560, 19'd305920}, {5'd0, 5'd0, 5'd2, 5'd1}, 8);
        vecs[7] = mk(100, 100, 0, 7, 0, {5'd1, 5'd1, 5'd1, 5'd1}, 0, '0, '0, 0);
        vecs[8] = mk(3, 3, 5, 0, 0, {5'd1, 5'd1, 5'd1, 5'd1}, 0, '0, '0, 0);

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        step();
        chk("reset cmd_ready", bus.cmd_ready, 1);
        chk("reset fb_we", bus.fb_we, 0);
        chk("reset done", bus.done, 0);
        chk("reset rom_addr", bus.rom_addr, 0);
        chk("reset fb_addr", bus.fb_addr, 0);
        chk("reset fb_data", bus.fb_data, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Frame buffer stalls the first write for five clocks.
        load_rom(vecs[0]);
        wq.delete();
        d0 = done_cnt;
        bus.fb_ready = 1'b0;
        @(posedge Clk); #1;
        drive_cmd(vecs[0]);
        bus.cmd_valid = 1'b1;
        @(posedge Clk); #1;
        bus.cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            found = int'(bus.fb_we);
        end
        chk("stall fb_we seen", found, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d fb_we", i), bus.fb_we, 1);
            chk($sformatf("stall%0d fb_addr", i), bus.fb_addr, 12810);
            chk($sformatf("stall%0d fb_data", i), bus.fb_data, 3);
            @(posedge Clk); #1;
        end
        bus.fb_ready = 1'b1;
        wait_and_check(vecs[0], 13, "stall", d0);

        // Reset lands in the WRITE cycle of the third pixel of a 4x4 blit.
        for (int i = 0; i < 16; i++) rom[i] = 5'd1;
        blk = mk(0, 0, 4, 4, 0, '0, 0, '0, '0, 0);
        wq.delete();
        d0 = done_cnt;
        @(posedge Clk); #1;
        drive_cmd(blk);
        bus.cmd_valid = 1'b1;
        @(posedge Clk); #1;
        bus.cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            found = int'(bus.fb_we && bus.fb_addr == 19'd2);
        end
        chk("abort third pixel reached", found, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("abort fb_we", bus.fb_we, 0);
        chk("abort done", bus.done, 0);
        chk("abort cmd_ready", bus.cmd_ready, 1);
        chk("abort rom_addr", bus.rom_addr, 0);
        n_w = wq.size();
        repeat (40) step();
        chk("abort no more writes", wq.size(), n_w);
        chk("abort no done", done_cnt, d0);
        for (int i = 0; i < 16; i++) rom[i] = 5'd0;
        run_vec(vecs[0], "after abort");

        // Command offered while reset is asserted is dropped.
        load_rom(vecs[0]);
        @(posedge Clk); #1;
        drive_cmd(vecs[0]);
        bus.cmd_valid = 1'b1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        bus.cmd_valid = 1'b0;
        n_w = wq.size();
        d0 = done_cnt;
        repeat (20) step();
        chk("reset+valid no writes", wq.size(), n_w);
        chk("reset+valid no done", done_cnt, d0);
        chk("reset+valid cmd_ready", bus.cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter SCREEN_W, default 640, visible frame-buffer width in pixels.
REQ-002 Parameter SCREEN_H, default 480, visible frame-buffer height in pixels.
REQ-003 Parameter TRANSPARENT, default 5'h1F, sprite colour code that is never written.
REQ-004 Clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high.
REQ-006 cmd_valid  in  1  blit command offered.
REQ-007 cmd_ready  out  1  blitter idle and accepting a command.
REQ-008 cmd_x  in  10  destination left column of the sprite.
REQ-009 cmd_y  in  10  destination top row of the sprite.
REQ-010 cmd_w  in  6  sprite width in pixels, 0..63.
REQ-011 cmd_h  in  6  sprite height in pixels, 0..63.
REQ-012 cmd_base  in  11  sprite ROM start address, row-major.
REQ-013 rom_addr  out  11  sprite ROM read address.
REQ-014 rom_data  in  5  ROM colour code, valid exactly 1 Clk after rom_addr.
REQ-015 fb_we  out  1  frame-buffer write strobe.
REQ-016 fb_addr  out  19  linear frame-buffer address, y*SCREEN_W+x.
REQ-017 fb_data  out  5  colour code written.
REQ-018 fb_ready  in  1  frame buffer accepts the write this cycle; low stalls.
REQ-019 done  out  1  one-cycle pulse when a blit completes.

Function
REQ-020 States IDLE, FETCH, WRITE; state register only changes on Clk.
REQ-021 IDLE: cmd_ready=1; cmd_valid=1 captures all cmd_* fields, zeroes col/row counters, loads ROM pointer with cmd_base, goes to FETCH.
REQ-022 Command with cmd_w=0 or cmd_h=0: no ROM reads, no writes, done pulses the cycle after acceptance, back to IDLE.
REQ-023 FETCH: drive rom_addr=pointer for one cycle, then go to WRITE.
REQ-024 WRITE: fb_data=rom_data registered on WRITE entry; held stable until the pixel retires.
REQ-025 Pixel write condition: code != TRANSPARENT and x+col < SCREEN_W and y+row < SCREEN_H (12-bit sums, no wrap).
REQ-026 Written pixel: fb_we=1 with fb_addr/fb_data stable until fb_ready=1 sampled; retires that cycle.
REQ-027 Skipped pixel (transparent or clipped): fb_we=0, retires in first WRITE cycle regardless of fb_ready.
REQ-028 Retire: pointer increments modulo 2048; col increments; at col=w-1 col wraps to 0 and row increments.
REQ-029 Retire of pixel (w-1,h-1): done=1 next cycle, state IDLE; otherwise back to FETCH.
REQ-030 Throughput: 2 Clk per pixel with fb_ready held high.
REQ-031 cmd_valid ignored outside IDLE; no queueing.
REQ-032 fb_addr = (Y<<9)+(Y<<7)+X for SCREEN_W=640, 19-bit result, Y=y+row, X=x+col.

Reset
REQ-033 Reset returns IDLE from any state, aborting mid-blit with no further writes.
REQ-034 Reset values: cmd_ready=1 (after reset cycle), fb_we=0, done=0, rom_addr=0, fb_addr=0, fb_data=0, counters 0.
REQ-035 Reset asserted with cmd_valid=1: command not accepted.

Structure
REQ-036 Shared package blit_pkg holds state enum, SCREEN_W/SCREEN_H defaults, TRANSPARENT default, address width 19.
REQ-037 One sub-module fb_addr_calc: combinational X,Y -> 19-bit linear address plus in-bounds flag.
REQ-038 All outputs registered except cmd_ready (decoded from state).

Verification
REQ-039 x=10,y=20,w=2,h=2,base=0, ROM={3,4,5,6}, fb_ready=1 -> writes (12810,3),(12811,4),(13450,5),(13451,6); done 8 Clk after accept.
REQ-040 Same command, ROM[1]=5'h1F -> only 3 fb_we pulses, addr 12811 never written, done timing unchanged.
REQ-041 x=639,y=479,w=2,h=2 -> single write at 307199; three pixels clipped; done pulses.
REQ-042 fb_ready held low 5 Clk on first write -> fb_we, fb_addr, fb_data stable all 5 Clk; completion delayed exactly 5 Clk.
REQ-043 w=0,h=7 -> zero ROM reads and writes, done 1 Clk after accept.
REQ-044 Reset asserted in WRITE of 3rd pixel of 4x4 blit -> fb_we=0 next cycle, no done, cmd_ready=1, new command accepted normally.
